// File: rtl/seq_alu_if.sv
// Request/response bundle between the EX-stage operand muxes and seq_alu.
// Ports: in_valid/in_ready handshake with alu_func, in_a, in_b on the request side;
//        out_valid/out_ready handshake with result, check, err on the response side.
interface seq_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_func;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            check;
  logic            err;

  // Requester side (operand muxes / writeback logic).
  modport master (
    output in_valid, alu_func, in_a, in_b, out_ready,
    input  in_ready, out_valid, result, check, err
  );

  // Execute unit side.
  modport slave (
    input  in_valid, alu_func, in_a, in_b, out_ready,
    output in_ready, out_valid, result, check, err
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: logic/arith/compare in one step, shifts one bit per cycle.
// Latency: 1 cycle for non-shift ops, max(1, amount) cycles for SLL/SRL/SRA.
// Backpressure: holds result in DONE until out_ready; in_ready is high only in IDLE.
// Ports: clk, rstn (async active-low), bus (seq_alu_if.slave: request + response handshakes).
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rstn,
  seq_alu_if.slave bus
);

  localparam int AW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_BGE  = 4'd10;
  localparam logic [3:0] OP_BGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] sh_q;
  logic [AW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            out_valid_q;
  logic            check_q;
  logic            err_q;

  logic [XLEN-1:0] res_d;
  logic            chk_d;
  logic            err_d;
  logic [AW-1:0]   amt;
  logic            is_shift;

  // One-position shift step shared by the accept edge and the SHIFT state.
  function automatic logic [XLEN-1:0] shift1(input logic [3:0] op, input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = {v[XLEN-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[XLEN-1:1]};
      default: r = {v[XLEN-1], v[XLEN-1:1]};  // SRA: MSB of in_a stays in place, so it sign-fills
    endcase
    return r;
  endfunction

  assign amt      = bus.in_b[AW-1:0];
  assign is_shift = (bus.alu_func == OP_SLL) || (bus.alu_func == OP_SRL) ||
                    (bus.alu_func == OP_SRA);

  // Single-step result for the op presented at the request port.
  always_comb begin
    res_d = '0;
    chk_d = 1'b0;
    err_d = 1'b0;
    case (bus.alu_func)
      OP_ADD:  res_d = bus.in_a + bus.in_b;
      OP_SUB: begin
        res_d = bus.in_a - bus.in_b;
        chk_d = (res_d != '0);
      end
      OP_XOR: begin
        res_d = bus.in_a ^ bus.in_b;
        chk_d = (res_d == '0);
      end
      OP_OR:   res_d = bus.in_a | bus.in_b;
      OP_AND:  res_d = bus.in_a & bus.in_b;
      OP_SLT: begin
        res_d = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
        chk_d = res_d[0];
      end
      OP_SLTU: begin
        res_d = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
        chk_d = res_d[0];
      end
      OP_BGE: begin
        res_d = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) >= $signed(bus.in_b))};
        chk_d = res_d[0];
      end
      OP_BGEU: begin
        res_d = {{(XLEN-1){1'b0}}, (bus.in_a >= bus.in_b)};
        chk_d = res_d[0];
      end
      // The first shift position is taken on the accept edge itself, so amount 1
      // finishes immediately and amount n needs only n-1 SHIFT cycles.
      OP_SLL, OP_SRL, OP_SRA:
        res_d = (amt == '0) ? bus.in_a : shift1(bus.alu_func, bus.in_a);
      OP_EEE:  err_d = 1'b1;
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      op_q        <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      check_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q <= bus.alu_func;
            if (is_shift && (amt > AW'(1))) begin
              // cnt_q counts shift positions still to go after this edge.
              sh_q    <= res_d;
              cnt_q   <= amt - AW'(1);
              state_q <= SHIFT;
            end else begin
              result_q    <= res_d;
              check_q     <= chk_d;
              err_q       <= err_d;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        SHIFT: begin
          sh_q  <= shift1(op_q, sh_q);
          cnt_q <= cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            result_q    <= shift1(op_q, sh_q);
            check_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready depends on state only, so no combinational path from in_valid/out_ready.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.check     = check_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu: reset, arithmetic, shifts, branch flags, illegal op, handshake.
module tb_seq_alu;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_BGE  = 4'd10;
  localparam logic [3:0] OP_BGEU = 4'd11;
  localparam logic [3:0] OP_EEE  = 4'd15;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  seq_alu_if #(.XLEN(32)) bus ();

  seq_alu #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and return the number of cycles until out_valid (64 = timeout).
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      output int lat);
    int w;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 64) begin
      tick();
      w++;
    end
    bus.in_valid = 1'b1;
    bus.alu_func = f;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int pulses;
    rstn = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL reset_check got=%b exp=0", bus.check); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    // Start a long SRA, then pull reset in the middle of it.
    bus.in_valid = 1'b1; bus.alu_func = OP_SRA; bus.in_a = 32'h8000_0000; bus.in_b = 32'd10;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midshift_busy in_ready got=%b exp=0", bus.in_ready); end
    rstn = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid cyc=%0d got=%b exp=0", c, bus.out_valid); end
      checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL midreset_result cyc=%0d got=%h exp=0", c, bus.result); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midreset_err cyc=%0d got=%b exp=0", c, bus.err); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready cyc=%0d got=%b exp=1", c, bus.in_ready); end
      tick();
    end
    rstn = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL post_reset_pulse got=%0d exp=0", pulses); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_add_sub();
    int lat;
    send(OP_ADD, 32'hFFFF_FFFF, 32'h2, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++; if (bus.result !== 32'h1) begin errors++; $display("FAIL add_result got=%h exp=00000001", bus.result); end
    checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL add_check got=%b exp=0", bus.check); end
    retire();
    send(OP_SUB, 32'd5, 32'd7, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sub_latency got=%0d exp=1", lat); end
    checks++; if (bus.result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffffffe", bus.result); end
    checks++; if (bus.check !== 1'b1) begin errors++; $display("FAIL sub_check got=%b exp=1", bus.check); end
    retire();
  endtask

  task automatic test_sra();
    int lat;
    send(OP_SRA, 32'h8000_0000, 32'h24, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sra4_latency got=%0d exp=4", lat); end
    checks++; if (bus.result !== 32'hF800_0000) begin errors++; $display("FAIL sra4_result got=%h exp=f8000000", bus.result); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sra4_err got=%b exp=0", bus.err); end
    retire();
    send(OP_SRA, 32'h8000_0000, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sra0_latency got=%0d exp=1", lat); end
    checks++; if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL sra0_result got=%h exp=80000000", bus.result); end
    retire();
  endtask

  task automatic test_branch();
    logic [3:0]  f   [3] = '{OP_XOR, OP_BGE, OP_BGEU};
    logic [31:0] a   [3] = '{32'h1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b   [3] = '{32'h1234, 32'h1, 32'h1};
    logic [31:0] res [3] = '{32'h0, 32'h0, 32'h1};
    logic        chk [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      send(f[i], a[i], b[i], lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL branch%0d_latency got=%0d exp=1", i, lat); end
      for (int s = 0; s < 5; s++) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL branch%0d_stall%0d out_valid got=%b exp=1", i, s, bus.out_valid); end
        checks++; if (bus.result !== res[i]) begin errors++; $display("FAIL branch%0d_stall%0d result got=%h exp=%h", i, s, bus.result, res[i]); end
        checks++; if (bus.check !== chk[i]) begin errors++; $display("FAIL branch%0d_stall%0d check got=%b exp=%b", i, s, bus.check, chk[i]); end
        tick();
      end
      retire();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL branch%0d_retire out_valid got=%b exp=0", i, bus.out_valid); end
    end
  endtask

  task automatic test_illegal();
    int lat;
    send(OP_EEE, 32'h55, 32'h0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL eee_latency got=%0d exp=1", lat); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL eee_result got=%h exp=0", bus.result); end
    checks++; if (bus.check !== 1'b0) begin errors++; $display("FAIL eee_check got=%b exp=0", bus.check); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL eee_err got=%b exp=1", bus.err); end
    retire();
    send(OP_ADD, 32'h1, 32'h1, lat);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL after_eee_err got=%b exp=0", bus.err); end
    checks++; if (bus.result !== 32'h2) begin errors++; $display("FAIL after_eee_result got=%h exp=2", bus.result); end
    retire();
  endtask

  task automatic test_ops();
    logic [3:0]  f   [12] = '{OP_OR, OP_AND, OP_SLT, OP_SLTU, OP_SLT, OP_SRL,
                              OP_SLL, OP_SRA, OP_SUB, OP_XOR, OP_SRL, 4'd12};
    logic [31:0] a   [12] = '{32'hF0F0_0000, 32'hF0F0_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd5, 32'h8000_0000, 32'h1, 32'h4000_0000,
                              32'd7, 32'd1, 32'h80, 32'h77};
    logic [31:0] b   [12] = '{32'h0F0F_00FF, 32'h0FF0_FFFF, 32'h1, 32'h1,
                              32'd5, 32'd4, 32'd1, 32'd2,
                              32'd7, 32'd2, 32'hFFFF_FFE3, 32'h1};
    logic [31:0] res [12] = '{32'hFFFF_00FF, 32'h00F0_1234, 32'h1, 32'h0,
                              32'h0, 32'h0800_0000, 32'h2, 32'h1000_0000,
                              32'h0, 32'h3, 32'h10, 32'h0};
    logic        chk [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        er  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          lt  [12] = '{1, 1, 1, 1, 1, 4, 1, 2, 1, 1, 3, 1};
    int lat;
    for (int i = 0; i < 12; i++) begin
      send(f[i], a[i], b[i], lat);
      checks++; if (lat !== lt[i]) begin errors++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, lat, lt[i]); end
      checks++; if (bus.result !== res[i]) begin errors++; $display("FAIL op%0d_result got=%h exp=%h", i, bus.result, res[i]); end
      checks++; if (bus.check !== chk[i]) begin errors++; $display("FAIL op%0d_check got=%b exp=%b", i, bus.check, chk[i]); end
      checks++; if (bus.err !== er[i]) begin errors++; $display("FAIL op%0d_err got=%b exp=%b", i, bus.err, er[i]); end
      retire();
    end
  endtask

  task automatic test_handshake();
    int lat;
    send(OP_OR, 32'hF0, 32'h0F, lat);
    retire();
    // SLL by 31 with the next request (ADD 1+2) held on the port throughout.
    bus.in_valid = 1'b1; bus.alu_func = OP_SLL; bus.in_a = 32'h3; bus.in_b = 32'd31;
    tick();
    bus.alu_func = OP_ADD; bus.in_a = 32'h1; bus.in_b = 32'h2;
    for (int c = 1; c <= 32; c++) begin
      if (c > 1) tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hs_in_ready cyc=%0d got=%b exp=0", c, bus.in_ready); end
      if (c <= 30) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hs_early_valid cyc=%0d got=%b exp=0", c, bus.out_valid); end
        checks++; if (bus.result !== 32'hFF) begin errors++; $display("FAIL hs_result_hold cyc=%0d got=%h exp=000000ff", c, bus.result); end
      end else begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hs_valid cyc=%0d got=%b exp=1", c, bus.out_valid); end
        checks++; if (bus.result !== 32'h8000_0000) begin errors++; $display("FAIL hs_sll_result cyc=%0d got=%h exp=80000000", c, bus.result); end
      end
      if (c == 32) bus.out_ready = 1'b1;
    end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hs_retire out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hs_retire in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hs_next_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.result !== 32'h3) begin errors++; $display("FAIL hs_next_result got=%h exp=3", bus.result); end
    retire();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_func  = 4'd0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b0;
    rstn          = 1'b0;
    test_reset();
    test_add_sub();
    test_sra();
    test_branch();
    test_illegal();
    test_ops();
    test_handshake();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle execute unit that consumes the 4-bit `alu_func` code produced by `alu_control`, together with two operands, and returns a result plus a branch-condition flag over a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. Shifts (`OP_SLL`, `OP_SRL`, `OP_SRA`) iterate one bit position per cycle, so no barrel shifter is needed. It sits in the EX stage of the multi-cycle datapath, between the operand muxes and the writeback/branch logic.

## Interface
- `XLEN`, default 32: operand and result width; must be a power of two and at least 8.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `alu_func`  in  4  operation code, using the `OP_*` encodings in `defines.v`.
- `in_a`  in  XLEN  operand A.
- `in_b`  in  XLEN  operand B; for shifts, only `in_b[$clog2(XLEN)-1:0]` is used as the shift amount.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  operation result.
- `check`  out  1  branch-condition flag.
- `err`  out  1  unsupported `alu_func` was accepted (includes `OP_EEE`).

## Operation
- FSM states and outputs:
  - IDLE: `in_ready`=1.
  - SHIFT: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- A request is accepted on a cycle where `in_valid` and `in_ready` are both 1. Opcode and operands are registered at that edge.
- IDLE, request accepted, non-shift op: compute and go to DONE.
- IDLE, request accepted, shift op with amount 0: `result` = `in_a`, go to DONE.
- IDLE, request accepted, shift op with amount > 0: load the shift register with `in_a` and the counter with the amount, then go to SHIFT.
- SHIFT: each cycle, shift by 1 and decrement the counter. When the counter reaches 1, the final shift is performed and the FSM moves to DONE.
- DONE: hold `result`, `check` and `err` stable until `out_ready`=1, then return to IDLE.
- Per-op behaviour:
  - ADD/SUB: modulo 2^XLEN, no overflow flag.
  - XOR/OR/AND: bitwise.
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: sign-fill from `in_a[XLEN-1]`.
  - SLT/BGE: signed compare. SLTU/BGEU: unsigned compare. `result` = {0…, cmp}, where cmp is a<b for SLT/SLTU and a>=b for BGE/BGEU.
- `check` rules:
  - OP_XOR: `check` = (`result`==0), i.e. beq taken.
  - OP_SUB: `check` = (`result`!=0), i.e. bne taken.
  - SLT/SLTU/BGE/BGEU: `check` = `result[0]`.
  - All other ops: `check` = 0.
- Any unsupported code: `result`=0, `check`=0, `err`=1. Completes in one cycle like a non-shift op.
- `err`=0 for every supported op.

## Timing
- Reset: asynchronous on `rstn`=0. FSM goes to IDLE; `out_valid`=0, `result`=0, `check`=0, `err`=0, shift counter=0. `in_ready` is 1 while `rstn`=0 and after release.
- Reset asserted mid-SHIFT or mid-DONE: the in-flight operation is discarded and no `out_valid` pulse follows.
- Latency, measured from the accept edge to the first cycle with `out_valid`=1:
  - non-shift ops: 1 cycle.
  - shift ops: max(1, amount) cycles (maximum XLEN-1).
- `in_ready` is combinational from the state only, never from `in_valid` or `out_ready`.
- `in_valid` asserted in SHIFT or DONE is ignored; the requester holds it until accepted.
- The DONE→IDLE edge and a new accept are never in the same cycle. Maximum throughput is therefore one op per 2 cycles, or amount+1 cycles for shifts.
- Outputs are registered. `result` changes only on the DONE entry edge.

## Test plan
- Reset check: hold `rstn`=0 for 3 cycles mid-stream, then release. Require `out_valid`=0, `result`=0, `err`=0 and `in_ready`=1, all within the reset window.
- ADD wrap: OP_ADD, a=0xFFFF_FFFF, b=0x2. Require `out_valid` 1 cycle after accept, `result`=0x1, `check`=0. SUB: a=5, b=7 gives 0xFFFF_FFFE, `check`=1.
- SRA iterate: OP_SRA, a=0x8000_0000, b=0x24 (amount 4). Require `out_valid` exactly 4 cycles after accept, `result`=0xF800_0000. Repeat with b=0: 1 cycle, `result`=0x8000_0000.
- Branch flags, each held with `out_ready`=0 for 5 cycles:
  - OP_XOR a=b=0x1234: `check`=1.
  - OP_BGE a=0xFFFF_FFFF, b=1: `check`=0, `result`=0.
  - OP_BGEU with the same operands: `check`=1.
  - In every case, outputs remain stable through the stall.
- Illegal op: OP_EEE with a=0x55. Require `result`=0, `check`=0, `err`=1, and `err`=0 on the next legal op.
- Handshake: assert `in_valid` continuously during an SLL by 31. Require `in_ready`=0 for 32 cycles after accept, `result`=a<<31, and the next op accepted only the cycle after `out_ready` retires DONE.
